i2c_write_engine: RTL
=====================

I2C_WRITE_ENGINE -- requirements
Module: i2c_write_engine

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, meaning iCLK frequency in Hz.
REQ-002 SHALL have parameter I2C_FREQ, default 20000, meaning SCL frequency in Hz.
REQ-003 SHALL define constant QDIV = CLK_FREQ/(4*I2C_FREQ) (625 at defaults), meaning iCLK cycles per SCL quarter-period; QDIV < 2 SHALL be an elaboration error.
REQ-004 SHALL use one clock and an asynchronous, active-low reset.
REQ-005 iCLK  input  1  system clock, all logic on rising edge.
REQ-006 iRST_N  input  1  asynchronous active-low reset.
REQ-007 iGO  input  1  level request; sampled only in IDLE.
REQ-008 iDATA  input  24  {slave_addr, sub_addr, data}, MSB first.
REQ-009 oBUSY  output  1  transaction in progress.
REQ-010 oDONE  output  1  one-cycle pulse at transaction end.
REQ-011 oACK_ERR  output  1  any of the 3 ACK slots sampled high; valid with oDONE, held until next start.
REQ-012 I2C_SCLK  output  1  SCL, push-pull.
REQ-013 I2C_SDAT  inout  1  SDA, open-drain: driven 0 or high-Z, never driven 1.

Function
REQ-014 States SHALL be IDLE, START, BIT, STOP, DONE; every state except IDLE and DONE lasts exactly 4 quarter-periods q0..q3.
REQ-015 IDLE: SCL=1, SDA released; iGO=1 at edge N latches iDATA, clears oACK_ERR, clears bit counter, enters START with oBUSY=1 at N+1 and quarter counter restarted from 0.
REQ-016 START: q0 SCL=1/SDA=1; q1 SCL=1/SDA=0; q2-q3 SCL=0/SDA=0.
REQ-017 BIT: 27 bit slots, counter 0..26; slots 8, 17, 26 are ACK slots (SDA released), others drive shift-register MSB.
REQ-018 Each BIT slot: q0 SCL=0 with SDA updated at q0 start; q1-q2 SCL=1; q3 SCL=0.
REQ-019 ACK slots SHALL sample synchronised SDA on the last iCLK of q2; a sampled 1 SHALL set oACK_ERR (sticky within the transaction).
REQ-020 The transfer SHALL NOT abort on NACK; all 27 slots and STOP always complete.
REQ-021 STOP: q0 SCL=0/SDA=0; q1 SCL=1/SDA=0; q2-q3 SCL=1/SDA released.
REQ-022 DONE: one cycle, oDONE=1, oBUSY=0, then IDLE.
REQ-023 Total duration from oBUSY rise to oDONE SHALL be 29*4*QDIV iCLK cycles (72500 at defaults).
REQ-024 iGO and iDATA changes while oBUSY=1 SHALL be ignored; iGO held high through DONE SHALL start the next transaction from IDLE one cycle after oDONE.
REQ-025 SDA input SHALL pass a 2-flop synchroniser before use.
REQ-026 Quarter counter SHALL be width clog2(QDIV), wrap QDIV-1 -> 0, and run only while oBUSY=1.

Reset
REQ-027 Reset asserted SHALL immediately force: state IDLE, oBUSY=0, oDONE=0, oACK_ERR=0, I2C_SCLK=1, SDA released, all counters and shift register 0.
REQ-028 Reset mid-transaction SHALL produce no STOP condition and no oDONE; after release, the block waits for iGO.

Structure
REQ-029 State enum, QDIV computation, slot count (27) and ACK-slot indices SHALL live in a shared package i2c_pkg.
REQ-030 Quarter-tick divider SHALL be the single sub-module i2c_qtick (enable in, tick out).

Verification (bench CLK_FREQ=400000, I2C_FREQ=10000, QDIV=10)
REQ-031 iDATA=24'h729803, iGO pulse, slave ACKs all -> SDA bits 0111_0010 A 1001_1000 A 0000_0011 A on SCL rises; oDONE after 1160 cycles; oACK_ERR=0.
REQ-032 Slave NACKs the second byte only -> all 27 slots plus STOP still emitted; oACK_ERR=1 at oDONE and held until next iGO.
REQ-033 iGO held high continuously -> back-to-back transactions, next oBUSY rise exactly 1 cycle after oDONE.
REQ-034 iRST_N low during slot 12 -> same cycle SCL=1, SDA high-Z, oBUSY=0; no oDONE; new iGO after release gives a full correct transaction.
REQ-035 iDATA changed to 24'hFFFFFF mid-transfer -> line data unchanged from latched 24'h729803.
REQ-036 Checker: SDA never driven 1; SDA changes only while SCL=0 except START/STOP edges.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C write engine.
// Holds the FSM state enum, quarter-period divider computation, slot count,
// ACK-slot positions and the bus-level decode used by the top-level FSM.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_BIT   = 3'd2,
        ST_STOP  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam int DATA_W    = 24;  // {slave_addr, sub_addr, data}
    localparam int NUM_SLOTS = 27;  // 24 data bits + 3 ACK slots
    localparam int SLOT_W    = 5;
    localparam int ACK_SLOT0 = 8;
    localparam int ACK_SLOT1 = 17;
    localparam int ACK_SLOT2 = 26;

    // iCLK cycles per SCL quarter-period.
    function automatic int calc_qdiv(input int clk_freq, input int i2c_freq);
        return clk_freq / (4 * i2c_freq);
    endfunction

    function automatic logic is_ack_slot(input logic [SLOT_W-1:0] slot);
        return (slot == SLOT_W'(ACK_SLOT0)) ||
               (slot == SLOT_W'(ACK_SLOT1)) ||
               (slot == SLOT_W'(ACK_SLOT2));
    endfunction

    // Bus levels for a given FSM position, returned as {scl, sda_low}.
    // sda_low=1 pulls SDA to 0; sda_low=0 releases the open-drain line.
    function automatic logic [1:0] line_levels(input state_e     st,
                                               input logic [1:0] qtr,
                                               input logic       ack_slot,
                                               input logic       data_bit);
        logic [1:0] lv;
        lv = 2'b10;
        unique case (st)
            ST_START: begin
                unique case (qtr)
                    2'd0:    lv = 2'b10;
                    2'd1:    lv = 2'b11;
                    default: lv = 2'b01;
                endcase
            end
            ST_BIT: begin
                lv[1] = (qtr == 2'd1) || (qtr == 2'd2);
                lv[0] = !ack_slot && !data_bit;
            end
            ST_STOP: begin
                unique case (qtr)
                    2'd0:    lv = 2'b01;
                    2'd1:    lv = 2'b11;
                    default: lv = 2'b10;
                endcase
            end
            default: lv = 2'b10;
        endcase
        return lv;
    endfunction

endpackage

// File: rtl/i2c_qtick.sv
// Quarter-period tick generator: emits a one-cycle tick on the last iCLK
// of every QDIV-cycle quarter while enabled; held at zero when disabled.
// Ports: clk_i, rst_n_i (async active-low), en_i (run), tick_o (quarter end).
module i2c_qtick #(
    parameter int QDIV = 625
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int CW = $clog2(QDIV);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          last;

    assign last   = (cnt_q == CW'(QDIV - 1));
    assign tick_o = en_i && last;

    // Clearing while disabled guarantees every transaction starts a fresh
    // quarter from count 0.
    always_comb begin
        cnt_d = cnt_q;
        if (!en_i) begin
            cnt_d = '0;
        end else if (last) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/i2c_write_engine.sv
// I2C 3-byte write engine: START, 27 bit slots (3 bytes + ACKs), STOP.
// Ports: iCLK/iRST_N, iGO/iDATA request, oBUSY/oDONE/oACK_ERR status,
// I2C_SCLK push-pull SCL, I2C_SDAT open-drain SDA (driven 0 or high-Z).
module i2c_write_engine
    import i2c_pkg::*;
#(
    parameter int CLK_FREQ = 50000000,
    parameter int I2C_FREQ = 20000
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic        iGO,
    input  logic [23:0] iDATA,
    output logic        oBUSY,
    output logic        oDONE,
    output logic        oACK_ERR,
    output logic        I2C_SCLK,
    inout  wire         I2C_SDAT
);

    localparam int QDIV = calc_qdiv(CLK_FREQ, I2C_FREQ);

    if (QDIV < 2) begin : g_bad_qdiv
        $error("i2c_write_engine: CLK_FREQ/(4*I2C_FREQ) must be at least 2");
    end

    state_e              state_q, state_d;
    logic [1:0]          qtr_q, qtr_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                ack_err_q, ack_err_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                scl_q, sda_low_q;
    logic [1:0]          line_d;
    logic                sda_meta_q, sda_sync_q;
    logic                qtick;

    i2c_qtick #(
        .QDIV(QDIV)
    ) u_qtick (
        .clk_i   (iCLK),
        .rst_n_i (iRST_N),
        .en_i    (busy_q),
        .tick_o  (qtick)
    );

    assign I2C_SDAT = sda_low_q ? 1'b0 : 1'bz;
    assign I2C_SCLK = scl_q;
    assign oBUSY    = busy_q;
    assign oDONE    = done_q;
    assign oACK_ERR = ack_err_q;

    always_comb begin
        state_d   = state_q;
        qtr_d     = qtr_q;
        slot_d    = slot_q;
        shift_d   = shift_q;
        ack_err_d = ack_err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (iGO) begin
                    state_d   = ST_START;
                    shift_d   = iDATA;
                    ack_err_d = 1'b0;
                    slot_d    = '0;
                    qtr_d     = '0;
                end
            end
            ST_START: begin
                if (qtick) begin
                    qtr_d = qtr_q + 2'd1;
                    if (qtr_q == 2'd3) begin
                        state_d = ST_BIT;
                    end
                end
            end
            ST_BIT: begin
                if (qtick) begin
                    qtr_d = qtr_q + 2'd1;
                    // Last iCLK of q2 is the centre of SCL high: sample ACK.
                    if (qtr_q == 2'd2 && is_ack_slot(slot_q) && sda_sync_q) begin
                        ack_err_d = 1'b1;
                    end
                    if (qtr_q == 2'd3) begin
                        // ACK slots consume no data, so the shifter only
                        // advances after a data slot.
                        if (!is_ack_slot(slot_q)) begin
                            shift_d = {shift_q[DATA_W-2:0], 1'b0};
                        end
                        if (slot_q == SLOT_W'(NUM_SLOTS - 1)) begin
                            state_d = ST_STOP;
                        end else begin
                            slot_d = slot_q + SLOT_W'(1);
                        end
                    end
                end
            end
            ST_STOP: begin
                if (qtick) begin
                    qtr_d = qtr_q + 2'd1;
                    if (qtr_q == 2'd3) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Bus pins and status flags are registered from next-state values so
        // they change glitch-free exactly at the start of each quarter.
        line_d = line_levels(state_d, qtr_d, is_ack_slot(slot_d), shift_d[DATA_W-1]);
        busy_d = (state_d == ST_START) || (state_d == ST_BIT) || (state_d == ST_STOP);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q    <= ST_IDLE;
            qtr_q      <= '0;
            slot_q     <= '0;
            shift_q    <= '0;
            ack_err_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            scl_q      <= 1'b1;
            sda_low_q  <= 1'b0;
            sda_meta_q <= 1'b1;
            sda_sync_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            qtr_q      <= qtr_d;
            slot_q     <= slot_d;
            shift_q    <= shift_d;
            ack_err_q  <= ack_err_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            scl_q      <= line_d[1];
            sda_low_q  <= line_d[0];
            sda_meta_q <= I2C_SDAT;
            sda_sync_q <= sda_meta_q;
        end
    end

endmodule
